fft_butterfly_unit: RTL and testbench

- Radix-2 DIT butterfly for the 16-point FFT datapath.
- One parameterised block covers the three butterfly flavours used by the stage pipeline:
  - no-twiddle real,
  - real-input with twiddle,
  - full complex.
- Computes X = A + W·B and Y = A − W·B with fixed-point twiddles.
- Outputs are registered, with one cycle of latency and a valid flag, so it can drop directly into the stage pipeline.

---
 rtl/fft_pkg.sv | 16 +
 rtl/fft_cmul_q14.sv | 45 ++++
 rtl/fft_butterfly_unit.sv | 92 +++++++++
 tb/tb_fft_butterfly_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point FFT datapath: butterfly mode encodings
// and default fixed-point widths.
package fft_pkg;

  typedef enum logic [1:0] {
    BFLY_NO_TW   = 2'd0,
    BFLY_REAL_TW = 2'd1,
    BFLY_CPLX    = 2'd2
  } bfly_mode_e;

  localparam int FFT_DATA_W  = 32;
  localparam int FFT_TW_W    = 16;
  localparam int FFT_TW_FRAC = 14;
  localparam int TW_ONE      = 16384;

endpackage

// File: rtl/fft_cmul_q14.sv
// Combinational complex multiply P = W*B with a fixed-point twiddle. Each
// component is formed at full precision, floor-shifted once after the sum,
// and wrapped to DATA_W bits.
module fft_cmul_q14
  import fft_pkg::*;
#(
  parameter int DATA_W  = FFT_DATA_W,
  parameter int TW_W    = FFT_TW_W,
  parameter int TW_FRAC = FFT_TW_FRAC
) (
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  input  logic signed [TW_W-1:0]   w_re,
  input  logic signed [TW_W-1:0]   w_im,
  output logic signed [DATA_W-1:0] p_re,
  output logic signed [DATA_W-1:0] p_im
);

  localparam int PW = DATA_W + TW_W + 1;

  logic signed [PW-1:0] b_re_x_s;
  logic signed [PW-1:0] b_im_x_s;
  logic signed [PW-1:0] w_re_x_s;
  logic signed [PW-1:0] w_im_x_s;
  logic signed [PW-1:0] sum_re_s;
  logic signed [PW-1:0] sum_im_s;
  logic signed [PW-1:0] sh_re_s;
  logic signed [PW-1:0] sh_im_s;

  assign b_re_x_s = {{(PW-DATA_W){b_re[DATA_W-1]}}, b_re};
  assign b_im_x_s = {{(PW-DATA_W){b_im[DATA_W-1]}}, b_im};
  assign w_re_x_s = {{(PW-TW_W){w_re[TW_W-1]}}, w_re};
  assign w_im_x_s = {{(PW-TW_W){w_im[TW_W-1]}}, w_im};

  // Full-precision cross products; PW bits hold the exact sum of two products.
  always_comb begin
    sum_re_s = (b_re_x_s * w_re_x_s) - (b_im_x_s * w_im_x_s);
    sum_im_s = (b_re_x_s * w_im_x_s) + (b_im_x_s * w_re_x_s);
    sh_re_s  = sum_re_s >>> TW_FRAC;
    sh_im_s  = sum_im_s >>> TW_FRAC;
    p_re     = sh_re_s[DATA_W-1:0];
    p_im     = sh_im_s[DATA_W-1:0];
  end

endmodule

// File: rtl/fft_butterfly_unit.sv
// Radix-2 DIT butterfly X = A + W*B, Y = A - W*B with one registered output
// stage and a valid flag; MODE selects the no-twiddle, real or complex flavour.
module fft_butterfly_unit
  import fft_pkg::*;
#(
  parameter int MODE    = 2,
  parameter int DATA_W  = FFT_DATA_W,
  parameter int TW_W    = FFT_TW_W,
  parameter int TW_FRAC = FFT_TW_FRAC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a_re,
  input  logic [DATA_W-1:0] a_im,
  input  logic [DATA_W-1:0] b_re,
  input  logic [DATA_W-1:0] b_im,
  input  logic [TW_W-1:0]   w_re,
  input  logic [TW_W-1:0]   w_im,
  output logic [DATA_W-1:0] x_re,
  output logic [DATA_W-1:0] x_im,
  output logic [DATA_W-1:0] y_re,
  output logic [DATA_W-1:0] y_im,
  output logic              out_valid
);

  logic [DATA_W-1:0] a_im_s;
  logic [DATA_W-1:0] p_re_s;
  logic [DATA_W-1:0] p_im_s;
  logic [DATA_W-1:0] x_re_s;
  logic [DATA_W-1:0] x_im_s;
  logic [DATA_W-1:0] y_re_s;
  logic [DATA_W-1:0] y_im_s;

  generate
    if (MODE == int'(BFLY_NO_TW)) begin : g_no_tw
      assign a_im_s = '0;
      assign p_re_s = b_re;
      assign p_im_s = '0;
    end else begin : g_tw
      logic [DATA_W-1:0] b_im_s;
      logic signed [DATA_W-1:0] p_re_w_s;
      logic signed [DATA_W-1:0] p_im_w_s;

      // The real-input flavour forces both imaginary inputs to zero.
      assign a_im_s = (MODE == int'(BFLY_REAL_TW)) ? '0 : a_im;
      assign b_im_s = (MODE == int'(BFLY_REAL_TW)) ? '0 : b_im;

      fft_cmul_q14 #(
        .DATA_W  (DATA_W),
        .TW_W    (TW_W),
        .TW_FRAC (TW_FRAC)
      ) u_cmul (
        .b_re (b_re),
        .b_im (b_im_s),
        .w_re (w_re),
        .w_im (w_im),
        .p_re (p_re_w_s),
        .p_im (p_im_w_s)
      );

      assign p_re_s = p_re_w_s;
      assign p_im_s = p_im_w_s;
    end
  endgenerate

  // Butterfly sums; results wrap modulo 2^DATA_W.
  always_comb begin
    x_re_s = a_re + p_re_s;
    x_im_s = a_im_s + p_im_s;
    y_re_s = a_re - p_re_s;
    y_im_s = a_im_s - p_im_s;
  end

  // Single output register stage; data loads every cycle, valid tracks in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_re      <= '0;
      x_im      <= '0;
      y_re      <= '0;
      y_im      <= '0;
      out_valid <= 1'b0;
    end else begin
      x_re      <= x_re_s;
      x_im      <= x_im_s;
      y_re      <= y_re_s;
      y_im      <= y_im_s;
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_fft_butterfly_unit.sv
// Directed self-checking bench: one butterfly instance per MODE sharing the
// same stimulus, with hand-computed expected results.
module tb_fft_butterfly_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] a_re, a_im, b_re, b_im;
  logic [15:0] w_re, w_im;

  logic [31:0] x_re0, x_im0, y_re0, y_im0;
  logic [31:0] x_re1, x_im1, y_re1, y_im1;
  logic [31:0] x_re2, x_im2, y_re2, y_im2;
  logic        ov0, ov1, ov2;

  int n_checks;
  int n_pass;

  fft_butterfly_unit #(.MODE(0)) u_bf0 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .x_re(x_re0), .x_im(x_im0), .y_re(y_re0), .y_im(y_im0), .out_valid(ov0)
  );

  fft_butterfly_unit #(.MODE(1)) u_bf1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .x_re(x_re1), .x_im(x_im1), .y_re(y_re1), .y_im(y_im1), .out_valid(ov1)
  );

  fft_butterfly_unit #(.MODE(2)) u_bf2 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .x_re(x_re2), .x_im(x_im2), .y_re(y_re2), .y_im(y_im2), .out_valid(ov2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks = n_checks + 1;
    if (obs === exp_v) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
               tag, $signed(obs), obs, $signed(exp_v), exp_v);
    end
  endtask

  task automatic drive(input logic v, input int ar, input int ai, input int br,
                       input int bi, input int wr, input int wi);
    in_valid = v;
    a_re = ar;
    a_im = ai;
    b_re = br;
    b_im = bi;
    w_re = wr[15:0];
    w_im = wi[15:0];
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic pat [4];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    #12;
    check_eq("rst_x_re", x_re2, 32'd0);
    check_eq("rst_y_im", y_im2, 32'd0);
    check_eq("rst_valid", {31'd0, ov2}, 32'd0);
    rst = 1'b0;

    // MODE 2 unit twiddle
    drive(1'b1, 100, 0, 50, 0, 16384, 0);
    step();
    check_eq("m2_unit_x_re", x_re2, 32'd150);
    check_eq("m2_unit_x_im", x_im2, 32'd0);
    check_eq("m2_unit_y_re", y_re2, 32'd50);
    check_eq("m2_unit_y_im", y_im2, 32'd0);
    check_eq("m2_unit_valid", {31'd0, ov2}, 32'd1);
    check_eq("m0_plain_x_re", x_re0, 32'd150);

    // MODE 2 twiddle -j
    drive(1'b1, 100, 0, 50, 20, 0, -16384);
    step();
    check_eq("m2_negj_x_re", x_re2, 32'd120);
    check_eq("m2_negj_x_im", x_im2, -32'sd50);
    check_eq("m2_negj_y_re", y_re2, 32'd80);
    check_eq("m2_negj_y_im", y_im2, 32'd50);

    // floor shift on negative product
    drive(1'b1, 0, 0, -3, 0, 8192, 0);
    step();
    check_eq("m2_floor_x_re", x_re2, -32'sd2);
    check_eq("m2_floor_y_re", y_re2, 32'd2);
    check_eq("m2_floor_x_im", x_im2, 32'd0);

    // shift applied after summing: 0.5 + 0.5 = 1, not 0 + 0
    drive(1'b1, 0, 0, 1, 1, 8192, 8192);
    step();
    check_eq("m2_sumshift_x_re", x_re2, 32'd0);
    check_eq("m2_sumshift_x_im", x_im2, 32'd1);
    check_eq("m2_sumshift_y_im", y_im2, -32'sd1);

    // MODE 0 wrap, twiddle ignored
    drive(1'b1, 32'h7FFFFFFF, 0, 1, 0, 123, 456);
    step();
    check_eq("m0_wrap_x_re", x_re0, 32'h80000000);
    check_eq("m0_wrap_y_re", y_re0, 32'h7FFFFFFE);
    check_eq("m0_wrap_x_im", x_im0, 32'd0);
    check_eq("m0_wrap_y_im", y_im0, 32'd0);

    // MODE 1 ignores imaginary inputs
    drive(1'b1, 10, 999, 4, -777, 16384, 0);
    step();
    check_eq("m1_x_re", x_re1, 32'd14);
    check_eq("m1_x_im", x_im1, 32'd0);
    check_eq("m1_y_re", y_re1, 32'd6);
    check_eq("m1_y_im", y_im1, 32'd0);
    check_eq("m1_valid", {31'd0, ov1}, 32'd1);

    // back-to-back stream, valid pattern 1,0,1,1
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(pat[i], 10 * i, 0, i, 0, 16384, 0);
      step();
      check_eq($sformatf("pipe_valid_%0d", i), {31'd0, ov2}, {31'd0, pat[i]});
      check_eq($sformatf("pipe_x_re_%0d", i), x_re2, 11 * i);
    end

    // asynchronous reset between edges
    drive(1'b1, 9, 0, 1, 0, 16384, 0);
    step();
    check_eq("pre_rst_x_re", x_re2, 32'd10);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", {31'd0, ov2}, 32'd0);
    check_eq("async_rst_x_re", x_re2, 32'd0);
    check_eq("async_rst_y_re", y_re2, 32'd0);
    check_eq("async_rst_m0_x_re", x_re0, 32'd0);
    drive(1'b1, 30, 0, 5, 0, 16384, 0);
    #1;
    rst = 1'b0;
    step();
    check_eq("post_rst_valid", {31'd0, ov2}, 32'd1);
    check_eq("post_rst_x_re", x_re2, 32'd35);
    check_eq("post_rst_y_re", y_re2, 32'd25);
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    step();
    check_eq("idle_valid", {31'd0, ov2}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
